probe_cond: RTL and testbench
=============================

// Module: probe_cond
// PURPOSE
//  Front-end conditioner feeding the on-chip analyzer probe bus, for debugging the a18 (pin 73) input.
//  Synchronises raw key1/a18 and debounces key1, which the operator uses to arm and re-arm the block.
//  Detects a18 edges and counts them over a fixed window after the first edge; records minimum a18 high width.
//  Outputs a packed probe bus plus a one-cycle trigger that the analyzer samples directly.
// PARAMETERS
//  SYNC_STAGES      2       flops per input synchroniser (>=2)
//  DEBOUNCE_CYCLES  270000  cycles key1 must be stable before debounced level changes (10 ms @ 27 MHz)
//  WINDOW_CYCLES    65535   capture window length in cycles after trigger
//  CNT_W            16      width of edge count and pulse-width registers
// PORTS
//  clk_i        in   1      single clock; all logic on rising edge
//  rst_i        in   1      asynchronous, active-high reset
//  key1_i       in   1      raw push button, async, active-high = pressed
//  a18_i        in   1      raw signal under test, async
//  trig_o       out  1      one-cycle pulse on first a18 edge while ARMED
//  done_o       out  1      high while in DONE
//  edge_cnt_o   out  CNT_W  a18 edges (both polarities) seen during window, saturating
//  min_hi_o     out  CNT_W  shortest complete a18 high pulse in window, in cycles, saturating
//  probe_o      out  6      {state[1:0], trig_o, key_db, key_s, a18_s} to analyzer data input
// BEHAVIOUR
//  Reset: every flop async-cleared; outputs 0 except min_hi_o = all-ones; state = IDLE.
//  Sync: key_s/a18_s = last flop of SYNC_STAGES chain; a18_d = a18_s delayed 1; edge = a18_s ^ a18_d.
//  Debounce: counter reloads on key_s != key_db; key_db <= key_s when counter reaches DEBOUNCE_CYCLES-1.
//  press = key_db rising (0->1), one cycle.
//  FSM states: IDLE=0, ARMED=1, CAPT=2, DONE=3.
//   IDLE : press -> ARMED; clear edge_cnt_o, min_hi_o <= all-ones, window ctr <= 0.
//   ARMED: edge -> CAPT, trig_o=1 that cycle (registered, visible next cycle); edge counted as 1.
//          press (no edge) -> IDLE (disarm). press and edge same cycle -> edge wins, goes CAPT.
//   CAPT : each edge increments edge_cnt_o (saturate at 2^CNT_W-1); window ctr increments;
//          ctr == WINDOW_CYCLES-1 -> DONE. press ignored.
//   DONE : done_o=1, counts frozen; press -> ARMED with counters cleared as in IDLE.
//  Latency: a18_i step first sampled at edge N -> a18_s at edge N+SYNC_STAGES-1 -> trig_o high
//   for edge N+SYNC_STAGES+1 only.
//  High width: hi_ctr clears on rising edge, increments while a18_s=1 (saturating); on falling edge
//   in CAPT, min_hi_o <= min(min_hi_o, hi_ctr). Pulse still high at window end is not recorded.
//   The rising edge that causes the trigger starts hi_ctr.
//  Edge on the final CAPT cycle is counted; edges in DONE ignored.
//  Reset mid-operation: immediate return to reset values; no partial results retained.
// STRUCTURE
//  probe_defs.vh: state encodings (ST_IDLE..ST_DONE), probe_o bit index defines.
//  Sub-module probe_sync: SYNC_STAGES-deep synchroniser, instantiated once per input.
//  Top holds debounce, edge detect, FSM, counters.
// TESTING (bench params SYNC_STAGES=2, DEBOUNCE_CYCLES=4, WINDOW_CYCLES=32, CNT_W=8)
//  1 reset held, toggle inputs -> all outputs 0, min_hi_o=8'hFF, probe_o state=0.
//  2 key1 high 3 cycles then low -> stays IDLE; high 10 cycles -> ARMED (probe_o[5:4]=1).
//  3 ARMED, a18 0->1 at edge N -> trig_o high for edge N+3 only; state CAPT.
//  4 in CAPT, a18 high pulses of 5 and 2 cycles -> at DONE edge_cnt_o=4, min_hi_o=2, done_o=1.
//  5 ARMED, key press with no a18 activity -> IDLE, trig_o never asserted.
//  6 rst_i pulsed mid-CAPT with edge_cnt_o=3 -> asynchronously 0, state IDLE, min_hi_o=8'hFF.

Source files
------------

// File: rtl/probe_cond_pkg.sv
// Shared definitions for the a18 probe conditioner: FSM encoding, probe bus layout, width helper.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package probe_cond_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CAPT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bit positions on the 6-bit analyzer probe bus
    localparam int PRB_A18_S  = 0;
    localparam int PRB_KEY_S  = 1;
    localparam int PRB_KEY_DB = 2;
    localparam int PRB_TRIG   = 3;
    localparam int PRB_ST_LO  = 4;
    localparam int PRB_ST_HI  = 5;
    localparam int PRB_W      = 6;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/probe_cond_sync.sv
// Multi-flop synchroniser bringing one asynchronous input into the clk_i domain.
// Latency: STAGES cycles from input sample to q_o.
// Backpressure: none; samples every cycle.
module probe_cond_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the flop chain; only the last flop is used downstream
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain[STAGES-1];

endmodule

// File: rtl/probe_cond.sv
// Conditions key1/a18 for the analyzer: sync, debounce, arm FSM, edge count and min-high-width capture.
// Latency: a18_i step sampled at edge N gives trig_o high for edge N+SYNC_STAGES+1 only.
// Backpressure: none; the analyzer samples the outputs every cycle.
module probe_cond
    import probe_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int WINDOW_CYCLES   = 65535,
    parameter int CNT_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             key1_i,
    input  logic             a18_i,
    output logic             trig_o,
    output logic             done_o,
    output logic [CNT_W-1:0] edge_cnt_o,
    output logic [CNT_W-1:0] min_hi_o,
    output logic [PRB_W-1:0] probe_o
);

    localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int WIN_W = cnt_width(WINDOW_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             key_s;
    logic             a18_s;
    logic             a18_d;
    logic             key_db;
    logic             key_db_d;
    logic [DB_W-1:0]  db_cnt;
    logic [CNT_W-1:0] hi_ctr;
    logic [WIN_W-1:0] win_ctr;
    state_t           state;

    logic a18_edge;
    logic a18_rise;
    logic a18_fall;
    logic press;

    probe_cond_sync #(.STAGES(SYNC_STAGES)) u_sync_key (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (key1_i),
        .q_o   (key_s)
    );

    probe_cond_sync #(.STAGES(SYNC_STAGES)) u_sync_a18 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (a18_i),
        .q_o   (a18_s)
    );

    assign a18_edge = a18_s ^ a18_d;
    assign a18_rise = a18_s & ~a18_d;
    assign a18_fall = ~a18_s & a18_d;
    assign press    = key_db & ~key_db_d;

    // Debounce: key_s must disagree with key_db for DEBOUNCE_CYCLES consecutive cycles to flip it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_db   <= 1'b0;
            key_db_d <= 1'b0;
            db_cnt   <= '0;
        end else begin
            key_db_d <= key_db;
            if (key_s == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                key_db <= key_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // High-width tracker: the rising-edge cycle is the first high cycle, so a W-cycle pulse reads W
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a18_d  <= 1'b0;
            hi_ctr <= '0;
        end else begin
            a18_d <= a18_s;
            if (a18_rise) begin
                hi_ctr <= CNT_W'(1);
            end else if (a18_s && hi_ctr != CNT_MAX) begin
                hi_ctr <= hi_ctr + 1'b1;
            end
        end
    end

    // Arm/capture FSM with registered trigger, done flag and capture results
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            trig_o     <= 1'b0;
            done_o     <= 1'b0;
            edge_cnt_o <= '0;
            min_hi_o   <= CNT_MAX;
            win_ctr    <= '0;
        end else begin
            trig_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (press) begin
                        state      <= ST_ARMED;
                        edge_cnt_o <= '0;
                        min_hi_o   <= CNT_MAX;
                        win_ctr    <= '0;
                    end
                end
                ST_ARMED: begin
                    // An edge takes priority over a simultaneous disarm press
                    if (a18_edge) begin
                        state      <= ST_CAPT;
                        trig_o     <= 1'b1;
                        edge_cnt_o <= CNT_W'(1);
                    end else if (press) begin
                        state <= ST_IDLE;
                    end
                end
                ST_CAPT: begin
                    if (a18_edge && edge_cnt_o != CNT_MAX) begin
                        edge_cnt_o <= edge_cnt_o + 1'b1;
                    end
                    if (a18_fall && hi_ctr < min_hi_o) begin
                        min_hi_o <= hi_ctr;
                    end
                    if (win_ctr == WIN_LAST) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                    end else begin
                        win_ctr <= win_ctr + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (press) begin
                        state      <= ST_ARMED;
                        done_o     <= 1'b0;
                        edge_cnt_o <= '0;
                        min_hi_o   <= CNT_MAX;
                        win_ctr    <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign probe_o = {state, trig_o, key_db, key_s, a18_s};

endmodule

// File: tb/tb_probe_cond.sv
// Directed bench for probe_cond with short debounce and window parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_probe_cond;

    logic       clk = 1'b0;
    logic       rst;
    logic       key1;
    logic       a18;
    logic       trig;
    logic       done;
    logic [7:0] edge_cnt;
    logic [7:0] min_hi;
    logic [5:0] probe;

    int checks   = 0;
    int failures = 0;

    probe_cond #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .WINDOW_CYCLES   (32),
        .CNT_W           (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .key1_i     (key1),
        .a18_i      (a18),
        .trig_o     (trig),
        .done_o     (done),
        .edge_cnt_o (edge_cnt),
        .min_hi_o   (min_hi),
        .probe_o    (probe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       key;
        logic       a18;
        int         ticks;
        logic [1:0] st;
        int         trigs;
        logic       done;
        logic [7:0] cnt;
        logic [7:0] mn;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic k, input logic a, input int n, input logic [1:0] st,
                       input int trigs, input logic dn, input logic [7:0] cnt, input logic [7:0] mn);
        vec_t v;
        v.key = k; v.a18 = a; v.ticks = n; v.st = st;
        v.trigs = trigs; v.done = dn; v.cnt = cnt; v.mn = mn;
        vecs.push_back(v);
    endtask

    initial begin
        int trigs;
        rst  = 1'b0;
        key1 = 1'b0;
        a18  = 1'b0;
        #2 rst = 1'b1;

        // Reset held while inputs toggle
        for (int i = 0; i < 6; i++) begin
            key1 = i[0];
            a18  = ~i[0];
            tick();
        end
        chk("rst_trig",  32'(trig),     32'h0);
        chk("rst_done",  32'(done),     32'h0);
        chk("rst_cnt",   32'(edge_cnt), 32'h0);
        chk("rst_min",   32'(min_hi),   32'hFF);
        chk("rst_probe", 32'(probe),    32'h0);
        key1 = 1'b0;
        a18  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();

        //  key a18 ticks  st trigs done cnt    min
        add(1, 0,  3,  0, 0, 0, 8'd0, 8'hFF);   // short press rejected
        add(0, 0,  8,  0, 0, 0, 8'd0, 8'hFF);
        add(1, 0, 10,  1, 0, 0, 8'd0, 8'hFF);   // long press arms
        add(0, 0,  8,  1, 0, 0, 8'd0, 8'hFF);   // release is not a press
        add(0, 1,  1,  1, 0, 0, 8'd0, 8'hFF);   // a18 step: edge N
        add(0, 1,  1,  1, 0, 0, 8'd0, 8'hFF);   // N+1
        add(0, 1,  1,  2, 1, 0, 8'd1, 8'hFF);   // trig visible for edge N+3
        add(0, 1,  1,  2, 0, 0, 8'd1, 8'hFF);   // trig gone
        add(0, 1,  1,  2, 0, 0, 8'd1, 8'hFF);   // 5-cycle pulse ends
        add(0, 0,  4,  2, 0, 0, 8'd2, 8'd5);
        add(0, 1,  2,  2, 0, 0, 8'd2, 8'd5);    // 2-cycle pulse
        add(0, 0,  6,  2, 0, 0, 8'd4, 8'd2);
        add(1, 0, 10,  2, 0, 0, 8'd4, 8'd2);    // press ignored in CAPT
        add(0, 0,  9,  3, 0, 1, 8'd4, 8'd2);    // window expired
        add(0, 1,  4,  3, 0, 1, 8'd4, 8'd2);    // edges in DONE ignored
        add(0, 0,  4,  3, 0, 1, 8'd4, 8'd2);
        add(1, 0,  8,  1, 0, 0, 8'd0, 8'hFF);   // re-arm from DONE clears
        add(0, 0,  8,  1, 0, 0, 8'd0, 8'hFF);
        add(1, 0,  8,  0, 0, 0, 8'd0, 8'hFF);   // press in ARMED disarms
        add(0, 0,  8,  0, 0, 0, 8'd0, 8'hFF);
        add(1, 0,  8,  1, 0, 0, 8'd0, 8'hFF);   // arm again
        add(0, 0,  8,  1, 0, 0, 8'd0, 8'hFF);
        add(1, 0,  4,  1, 0, 0, 8'd0, 8'hFF);   // press and edge land together
        add(1, 1,  3,  2, 1, 0, 8'd1, 8'hFF);   // edge wins
        add(0, 1, 29,  2, 0, 0, 8'd1, 8'hFF);
        add(0, 0,  2,  2, 0, 0, 8'd1, 8'hFF);   // last CAPT cycle pending
        add(0, 0,  1,  3, 0, 1, 8'd2, 8'h20);   // falling edge on final cycle recorded

        foreach (vecs[i]) begin
            key1  = vecs[i].key;
            a18   = vecs[i].a18;
            trigs = 0;
            for (int t = 0; t < vecs[i].ticks; t++) begin
                tick();
                if (trig === 1'b1) trigs++;
            end
            chk($sformatf("v%0d_state", i), 32'(probe[5:4]), 32'(vecs[i].st));
            chk($sformatf("v%0d_trigs", i), 32'(trigs),      32'(vecs[i].trigs));
            chk($sformatf("v%0d_done",  i), 32'(done),       32'(vecs[i].done));
            chk($sformatf("v%0d_cnt",   i), 32'(edge_cnt),   32'(vecs[i].cnt));
            chk($sformatf("v%0d_min",   i), 32'(min_hi),     32'(vecs[i].mn));
        end

        // Asynchronous reset in the middle of a capture
        key1 = 1'b1;
        repeat (8) tick();
        key1 = 1'b0;
        repeat (8) tick();
        chk("mid_armed", 32'(probe[5:4]), 32'd1);
        a18 = 1'b1;
        repeat (3) tick();
        a18 = 1'b0;
        repeat (3) tick();
        a18 = 1'b1;
        repeat (3) tick();
        chk("mid_state", 32'(probe[5:4]), 32'd2);
        chk("mid_cnt",   32'(edge_cnt),   32'd3);
        chk("mid_min",   32'(min_hi),     32'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 32'(probe[5:4]), 32'd0);
        chk("arst_cnt",   32'(edge_cnt),   32'd0);
        chk("arst_min",   32'(min_hi),     32'hFF);
        chk("arst_done",  32'(done),       32'd0);
        chk("arst_probe", 32'(probe),      32'd0);
        a18 = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("post_state", 32'(probe[5:4]), 32'd0);
        chk("post_cnt",   32'(edge_cnt),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
